// File: rtl/lane_bank_mem_if.sv
// Bus bundle for lane_bank_mem: read-pass control, serial/chunk write inputs and per-lane read outputs.
// Master drives the store, slave is the store itself.
interface lane_bank_mem_if #(
    parameter int LANES   = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int REGIONS = 32
);
    localparam int CNT_W  = $clog2(DEPTH);
    localparam int REG_W  = $clog2(REGIONS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                      enable;
    logic                      rd_start;
    logic [REG_W-1:0]          rd_region;
    logic [CNT_W-1:0]          size;
    logic [1:0]                wr_mode;
    logic [REG_W-1:0]          wr_region;
    logic [DATA_W-1:0]         wr_data;
    logic [LANES*DATA_W-1:0]   chunk_data;
    logic [LANES-1:0]          chunk_valid;
    logic [LANES*DATA_W-1:0]   rd_data;
    logic [LANES-1:0]          rd_valid;
    logic [LANES-1:0]          rd_first;
    logic                      rd_done;
    logic                      rd_busy;
    logic [LANE_W-1:0]         wr_lane;
    logic                      wr_done;

    modport master (
        output enable, rd_start, rd_region, size, wr_mode, wr_region, wr_data,
               chunk_data, chunk_valid,
        input  rd_data, rd_valid, rd_first, rd_done, rd_busy, wr_lane, wr_done
    );

    modport slave (
        input  enable, rd_start, rd_region, size, wr_mode, wr_region, wr_data,
               chunk_data, chunk_valid,
        output rd_data, rd_valid, rd_first, rd_done, rd_busy, wr_lane, wr_done
    );
endinterface

// File: rtl/lane_bank_mem.sv
// Multi-lane operand store: LANES banks of REGIONS x DEPTH words, skewed read passes for a systolic array.
// Define LBM_ACC_SAT_EN to make chunk accumulate a signed saturating add instead of a wrapping add.
module lane_bank_mem #(
    parameter int LANES   = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int REGIONS = 32
) (
    input  logic            clk,
    input  logic            reset,
    lane_bank_mem_if.slave  bus
);
    localparam int CNT_W  = $clog2(DEPTH);
    localparam int REG_W  = $clog2(REGIONS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ADDR_W = REG_W + CNT_W;
    localparam int WORDS  = REGIONS * DEPTH;

    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
`ifdef LBM_ACC_SAT_EN
        if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
            s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
        return s;
    endfunction

    // ---------------- write-side indexing ----------------
    logic [1:0]        prev_mode_reg;
    logic [CNT_W-1:0]  widx_reg, widx_next, eff_widx;
    logic [CNT_W-1:0]  cidx_reg, cidx_next, eff_cidx;
    logic [LANE_W-1:0] wr_lane_reg, wr_lane_next, eff_lane;
    logic              wr_done_reg, wr_done_next;
    logic              mode_chg;

    // A mode change restarts all write indices in the very cycle it is seen.
    assign mode_chg = (bus.wr_mode != prev_mode_reg);
    assign eff_widx = mode_chg ? '0 : widx_reg;
    assign eff_cidx = mode_chg ? '0 : cidx_reg;
    assign eff_lane = mode_chg ? '0 : wr_lane_reg;

    always_comb begin
        widx_next    = eff_widx;
        cidx_next    = eff_cidx;
        wr_lane_next = eff_lane;
        wr_done_next = 1'b0;
        if (bus.wr_mode == 2'd1) begin
            if (eff_widx >= bus.size) begin
                widx_next = '0;
                if (eff_lane == LANE_W'(LANES - 1)) begin
                    wr_lane_next = '0;
                    wr_done_next = 1'b1;
                end else begin
                    wr_lane_next = eff_lane + LANE_W'(1);
                end
            end else begin
                widx_next = eff_widx + CNT_W'(1);
            end
        end else if (bus.wr_mode[1] && (|bus.chunk_valid)) begin
            cidx_next = (eff_cidx >= bus.size) ? '0 : eff_cidx + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_mode_reg <= 2'd0;
            widx_reg      <= '0;
            cidx_reg      <= '0;
            wr_lane_reg   <= '0;
            wr_done_reg   <= 1'b0;
        end else if (bus.enable) begin
            prev_mode_reg <= bus.wr_mode;
            widx_reg      <= widx_next;
            cidx_reg      <= cidx_next;
            wr_lane_reg   <= wr_lane_next;
            wr_done_reg   <= wr_done_next;
        end
    end

    assign bus.wr_lane = wr_lane_reg;
    assign bus.wr_done = wr_done_reg;

    // ---------------- read skew chain and banks ----------------
    logic             start_acc;
    logic             rd_busy_reg, rd_done_reg;
    logic             lane_start  [LANES];
    logic [REG_W-1:0] start_region[LANES];
    logic [CNT_W-1:0] start_size  [LANES];
    logic             lane_last   [LANES];

    assign start_acc = bus.enable && bus.rd_start && !rd_busy_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] mem [WORDS];
        logic              run_reg, valid_reg, first_reg;
        logic [CNT_W-1:0]  idx_reg, size_reg, cur_idx, cur_size;
        logic [REG_W-1:0]  region_reg, cur_region;
        logic [DATA_W-1:0] data_reg, acc_word, wdata;
        logic [ADDR_W-1:0] raddr, waddr;
        logic              issue, we;

        if (gi == 0) begin : g_head
            assign lane_start[gi]   = start_acc;
            assign start_region[gi] = bus.rd_region;
            assign start_size[gi]   = bus.size;
        end else begin : g_skew
            logic             s_reg;
            logic [REG_W-1:0] r_reg;
            logic [CNT_W-1:0] z_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s_reg <= 1'b0;
                    r_reg <= '0;
                    z_reg <= '0;
                end else if (bus.enable) begin
                    s_reg <= lane_start[gi-1];
                    r_reg <= start_region[gi-1];
                    z_reg <= start_size[gi-1];
                end
            end
            assign lane_start[gi]   = s_reg;
            assign start_region[gi] = r_reg;
            assign start_size[gi]   = z_reg;
        end

        // The start cycle reads word 0 straight from the chain so output latency is one cycle.
        assign issue      = lane_start[gi] || run_reg;
        assign cur_idx    = lane_start[gi] ? '0 : idx_reg;
        assign cur_region = lane_start[gi] ? start_region[gi] : region_reg;
        assign cur_size   = lane_start[gi] ? start_size[gi] : size_reg;
        assign raddr      = {cur_region, cur_idx};
        assign lane_last[gi] = issue && (cur_idx == cur_size);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                run_reg    <= 1'b0;
                idx_reg    <= '0;
                region_reg <= '0;
                size_reg   <= '0;
                valid_reg  <= 1'b0;
                first_reg  <= 1'b0;
                data_reg   <= '0;
            end else if (bus.enable) begin
                run_reg    <= issue && !lane_last[gi];
                idx_reg    <= cur_idx + CNT_W'(1);
                region_reg <= cur_region;
                size_reg   <= cur_size;
                valid_reg  <= issue;
                first_reg  <= issue && (cur_idx == '0);
                data_reg   <= issue ? mem[raddr] : '0;
            end
        end

        // Accumulate reads the current word combinationally so back-to-back adds chain.
        assign acc_word = acc_add(mem[{bus.wr_region, eff_cidx}],
                                  bus.chunk_data[gi*DATA_W +: DATA_W]);
        assign we = bus.enable &&
                    (((bus.wr_mode == 2'd1) && (eff_lane == LANE_W'(gi))) ||
                     (bus.wr_mode[1] && bus.chunk_valid[gi]));
        assign waddr = (bus.wr_mode == 2'd1) ? {bus.wr_region, eff_widx}
                                             : {bus.wr_region, eff_cidx};
        assign wdata = (bus.wr_mode == 2'd1) ? bus.wr_data :
                       (bus.wr_mode == 2'd3) ? acc_word :
                                               bus.chunk_data[gi*DATA_W +: DATA_W];

        always_ff @(posedge clk) begin
            if (we)
                mem[waddr] <= wdata;
        end

        assign bus.rd_data[gi*DATA_W +: DATA_W] = data_reg;
        assign bus.rd_valid[gi] = valid_reg;
        assign bus.rd_first[gi] = first_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_done_reg <= 1'b0;
            rd_busy_reg <= 1'b0;
        end else if (bus.enable) begin
            rd_done_reg <= lane_last[LANES-1];
            if (start_acc)
                rd_busy_reg <= 1'b1;
            else if (rd_done_reg)
                rd_busy_reg <= 1'b0;
        end
    end

    assign bus.rd_done = rd_done_reg;
    assign bus.rd_busy = rd_busy_reg;
endmodule

// File: tb/tb_lane_bank_mem.sv
// Directed bench for lane_bank_mem: serial fill, skewed reads, chunk overwrite/accumulate,
// saturation (follows LBM_ACC_SAT_EN), partial chunk strobes, async reset mid-read and enable hold.
module tb_lane_bank_mem;
    localparam int LANES   = 8;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 64;
    localparam int REGIONS = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lane_bank_mem_if #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .REGIONS(REGIONS)) bus();

    lane_bank_mem #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .REGIONS(REGIONS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] got [LANES][8];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_chunk(input logic [1:0] mode, input logic [LANES-1:0] valid,
                             input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] lane_inc);
        bus.wr_mode     = mode;
        bus.chunk_valid = valid;
        for (int k = 0; k < LANES; k++)
            bus.chunk_data[k*DATA_W +: DATA_W] = base + lane_inc * DATA_W'(k);
    endtask

    // One read pass; checks per-cycle control timing and captures each lane's words into got.
    task automatic run_read(input logic [4:0] region, input int sz, input bit poke);
        logic [LANES-1:0]  ev, ef;
        logic [DATA_W-1:0] stray;
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 8; j++)
                got[k][j] = '0;
        bus.size      = 6'(sz);
        bus.rd_region = region;
        bus.rd_start  = 1'b1;
        step;
        bus.rd_start = 1'b0;
        for (int t = 1; t <= LANES + sz + 1; t++) begin
            ev = '0;
            ef = '0;
            stray = '0;
            for (int k = 0; k < LANES; k++) begin
                if (t >= k + 1 && t <= k + 1 + sz) begin
                    ev[k] = 1'b1;
                    got[k][t-k-1] = bus.rd_data[k*DATA_W +: DATA_W];
                end else begin
                    stray = stray | bus.rd_data[k*DATA_W +: DATA_W];
                end
                if (t == k + 1)
                    ef[k] = 1'b1;
            end
            check_eq("rd_valid", 64'(bus.rd_valid), 64'(ev));
            check_eq("rd_first", 64'(bus.rd_first), 64'(ef));
            check_eq("rd_done",  64'(bus.rd_done),  64'(t == LANES + sz));
            check_eq("rd_busy",  64'(bus.rd_busy),  64'(t <= LANES + sz));
            check_eq("rd_idle_zero", 64'(stray), 64'(0));
            $display("read r=%0d t=%0d valid=%b first=%b done=%b busy=%b",
                     region, t, bus.rd_valid, bus.rd_first, bus.rd_done, bus.rd_busy);
            bus.rd_start = poke && (t == 3);
            step;
        end
        bus.rd_start = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_w;
        logic [DATA_W-1:0] any_data;
        int pulses;

        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.rd_start    = 1'b0;
        bus.rd_region   = '0;
        bus.size        = '0;
        bus.wr_mode     = 2'd0;
        bus.wr_region   = '0;
        bus.wr_data     = '0;
        bus.chunk_data  = '0;
        bus.chunk_valid = '0;
        step;
        step;
        reset = 1'b0;
        step;

        check_eq("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
        check_eq("reset_rd_busy",  64'(bus.rd_busy),  64'(0));
        check_eq("reset_wr_lane",  64'(bus.wr_lane),  64'(0));
        check_eq("reset_wr_done",  64'(bus.wr_done),  64'(0));
        check_eq("reset_rd_data_or", 64'(|bus.rd_data), 64'(0));

        // Serial fill: lane k index j gets 4k+j.
        bus.size      = 6'd3;
        bus.wr_region = 5'd2;
        bus.wr_mode   = 2'd1;
        pulses = 0;
        for (int c = 0; c < 32; c++) begin
            check_eq("serial_wr_lane", 64'(bus.wr_lane), 64'((c / 4) % 8));
            bus.wr_data = DATA_W'(c);
            step;
            if (bus.wr_done) pulses++;
            check_eq("serial_wr_done", 64'(bus.wr_done), 64'(c == 31));
        end
        bus.wr_mode = 2'd0;
        step;
        check_eq("serial_wr_done_clear", 64'(bus.wr_done), 64'(0));
        check_eq("serial_done_pulses", 64'(pulses), 64'(1));
        $display("serial fill done pulses=%0d", pulses);

        // Skewed read with an ignored rd_start while busy.
        run_read(5'd2, 3, 1'b1);
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 4; j++)
                check_eq($sformatf("serial_read_l%0d_w%0d", k, j), 64'(got[k][j]), 64'(4*k + j));

        // Chunk overwrite 5, then two back-to-back accumulates of 7 at index 0.
        bus.size      = 6'd0;
        bus.wr_region = 5'd5;
        set_chunk(2'd2, 8'hFF, 32'd5, 32'd0);
        step;
        set_chunk(2'd3, 8'hFF, 32'd7, 32'd0);
        step;
        step;
        set_chunk(2'd0, 8'h00, 32'd0, 32'd0);
        step;
        run_read(5'd5, 0, 1'b0);
        for (int k = 0; k < LANES; k++)
            check_eq($sformatf("acc_chain_l%0d", k), 64'(got[k][0]), 64'(19));
        $display("chunk accumulate chain lane0=%0d", got[0][0]);

        // Saturation: positive overflow on lane 0, negative overflow on lane 1.
        bus.wr_region = 5'd6;
        bus.wr_mode   = 2'd2;
        bus.chunk_valid = 8'b0000_0011;
        bus.chunk_data  = '0;
        bus.chunk_data[0 +: DATA_W]      = 32'h7FFF_FFF0;
        bus.chunk_data[DATA_W +: DATA_W] = 32'h8000_0010;
        step;
        bus.wr_mode = 2'd3;
        bus.chunk_data[0 +: DATA_W]      = 32'h0000_0020;
        bus.chunk_data[DATA_W +: DATA_W] = 32'hFFFF_FF00;
        step;
        set_chunk(2'd0, 8'h00, 32'd0, 32'd0);
        step;
        run_read(5'd6, 0, 1'b0);
`ifdef LBM_ACC_SAT_EN
        check_eq("sat_pos", 64'(got[0][0]), 64'(32'h7FFF_FFFF));
        check_eq("sat_neg", 64'(got[1][0]), 64'(32'h8000_0000));
`else
        check_eq("wrap_pos", 64'(got[0][0]), 64'(32'h8000_0010));
        check_eq("wrap_neg", 64'(got[1][0]), 64'(32'h7FFF_FF10));
`endif
        $display("accumulate overflow lane0=%h lane1=%h", got[0][0], got[1][0]);

        // Partial chunk strobes: only strobed lanes change, cidx steps once per strobed cycle.
        bus.size      = 6'd3;
        bus.wr_region = 5'd7;
        for (int j = 0; j < 4; j++) begin
            set_chunk(2'd2, 8'hFF, DATA_W'(j), 32'd16);
            step;
        end
        set_chunk(2'd2, 8'h00, 32'd0, 32'd0);
        step;
        set_chunk(2'd2, 8'b0000_0101, 32'hAA00, 32'd1);
        step;
        set_chunk(2'd2, 8'b0000_0001, 32'hBB, 32'd0);
        step;
        set_chunk(2'd0, 8'h00, 32'd0, 32'd0);
        step;
        run_read(5'd7, 3, 1'b0);
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 4; j++) begin
                exp_w = DATA_W'(16*k + j);
                if (k == 0 && j == 0) exp_w = 32'hAA00;
                if (k == 0 && j == 1) exp_w = 32'hBB;
                if (k == 2 && j == 0) exp_w = 32'hAA02;
                check_eq($sformatf("partial_l%0d_w%0d", k, j), 64'(got[k][j]), 64'(exp_w));
            end
        $display("partial chunk lane0=%h,%h lane2=%h", got[0][0], got[0][1], got[2][0]);

        // Async reset while lane 3 is presenting data.
        bus.size      = 6'd3;
        bus.rd_region = 5'd2;
        bus.rd_start  = 1'b1;
        step;
        bus.rd_start = 1'b0;
        step;
        step;
        step;
        check_eq("midread_lane3_valid", 64'(bus.rd_valid[3]), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        any_data = '0;
        for (int k = 0; k < LANES; k++)
            any_data = any_data | bus.rd_data[k*DATA_W +: DATA_W];
        check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        check_eq("rst_rd_first", 64'(bus.rd_first), 64'(0));
        check_eq("rst_rd_done",  64'(bus.rd_done),  64'(0));
        check_eq("rst_rd_busy",  64'(bus.rd_busy),  64'(0));
        check_eq("rst_rd_data",  64'(any_data),     64'(0));
        check_eq("rst_wr_lane",  64'(bus.wr_lane),  64'(0));
        $display("reset mid-read outputs cleared");
        step;
        reset = 1'b0;
        step;
        run_read(5'd2, 3, 1'b0);
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 4; j++)
                check_eq($sformatf("postrst_l%0d_w%0d", k, j), 64'(got[k][j]), 64'(4*k + j));

        // Enable low: rd_start and serial writes must not change any state.
        bus.enable   = 1'b0;
        bus.rd_start = 1'b1;
        bus.wr_mode  = 2'd1;
        step;
        step;
        check_eq("hold_rd_busy",  64'(bus.rd_busy),  64'(0));
        check_eq("hold_rd_valid", 64'(bus.rd_valid), 64'(0));
        check_eq("hold_wr_lane",  64'(bus.wr_lane),  64'(0));
        $display("enable hold busy=%b wr_lane=%0d", bus.rd_busy, bus.wr_lane);
        bus.rd_start = 1'b0;
        bus.wr_mode  = 2'd0;
        bus.enable   = 1'b1;
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
